// File: rtl/vga_sync_gen.sv
// vga_sync_gen: VGA raster timing generator.
//
// Advances a horizontal/vertical pixel counter by one position on every
// pixel_en strobe and decodes hsync, vsync, video_on and the line/frame
// start pulses from the next count value. Every output is registered, so
// the decoded flags are aligned with pixel_x/pixel_y in the same cycle.
//
// Ports:
//   clk         in   system clock
//   reset       in   asynchronous reset, active low
//   pixel_en    in   one-clk strobe, advance raster by one pixel
//   hsync       out  horizontal sync, asserted level = SYNC_POL
//   vsync       out  vertical sync, asserted level = SYNC_POL
//   video_on    out  high while (pixel_x, pixel_y) is in the active area
//   pixel_x     out  current horizontal count [9:0]
//   pixel_y     out  current vertical count [9:0]
//   line_start  out  one-clk pulse when pixel_x becomes 0
//   frame_start out  one-clk pulse when (pixel_x, pixel_y) becomes (0, 0)
//   frame_count out  [15:0] frames started since reset, wraps at 16'hFFFF
//                    (present only when VGA_SYNC_FRAME_CNT_EN is defined)
//
// Optional feature macro: VGA_SYNC_FRAME_CNT_EN
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pixel_en,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_start,
`ifdef VGA_SYNC_FRAME_CNT_EN
  output logic        frame_start,
  output logic [15:0] frame_count
`else
  output logic        frame_start
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Sync level for a count: asserted inside [first, last], idle elsewhere.
  function automatic logic sync_level(input logic [9:0] cnt,
                                      input logic [9:0] first,
                                      input logic [9:0] last);
    return ((cnt >= first) && (cnt <= last)) ? SYNC_POL : ~SYNC_POL;
  endfunction

  logic [9:0] pixel_x_q, pixel_x_d;
  logic [9:0] pixel_y_q, pixel_y_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       video_on_q, video_on_d;
  logic       line_start_q, line_start_d;
  logic       frame_start_q, frame_start_d;

  always_comb begin
    pixel_x_d     = pixel_x_q;
    pixel_y_d     = pixel_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    video_on_d    = video_on_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (pixel_en) begin
      if (pixel_x_q == H_LAST) begin
        pixel_x_d = '0;
        pixel_y_d = (pixel_y_q == V_LAST) ? '0 : pixel_y_q + 10'd1;
      end else begin
        pixel_x_d = pixel_x_q + 10'd1;
      end

      // Decode from the next count so flags line up with the counters.
      hsync_d       = sync_level(pixel_x_d, HS_FIRST, HS_LAST);
      vsync_d       = sync_level(pixel_y_d, VS_FIRST, VS_LAST);
      video_on_d    = (pixel_x_d < H_VIS) && (pixel_y_d < V_VIS);
      line_start_d  = (pixel_x_d == '0);
      frame_start_d = (pixel_x_d == '0) && (pixel_y_d == '0);
    end
  end

  // Reset parks the raster on the last position so the first strobe lands on (0,0).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel_x_q     <= H_LAST;
      pixel_y_q     <= V_LAST;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign pixel_x     = pixel_x_q;
  assign pixel_y     = pixel_y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] frame_count_q, frame_count_d;

  // Counts on the same edge that loads (0,0); natural 16-bit wrap.
  always_comb begin
    frame_count_d = frame_count_q;
    if (frame_start_d) begin
      frame_count_d = frame_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count_q <= '0;
    end else begin
      frame_count_q <= frame_count_d;
    end
  end

  assign frame_count = frame_count_q;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

  logic       clk;
  logic       rst_n;
  logic       pixel_en;

  // Full-size 640x480 instance.
  logic       hs, vs, von, ls, fs;
  logic [9:0] px, py;

  // Reduced raster: 16 x 12 total, hsync on x 10..12, vsync on y 8..9,
  // active area 8 x 6. Lets whole frames run in a few hundred clocks.
  logic       hs_s, vs_s, von_s, ls_s, fs_s;
  logic [9:0] px_s, py_s;

`ifdef VGA_SYNC_FRAME_CNT_EN
  logic [15:0] fc, fc_s;
`endif

  int total = 0;
  int bad   = 0;

  vga_sync_gen dut (
    .clk         (clk),
    .reset       (rst_n),
    .pixel_en    (pixel_en),
    .hsync       (hs),
    .vsync       (vs),
    .video_on    (von),
    .pixel_x     (px),
    .pixel_y     (py),
    .line_start  (ls),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_start (fs),
    .frame_count (fc)
`else
    .frame_start (fs)
`endif
  );

  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2),
    .SYNC_POL(1'b0)
  ) dut_s (
    .clk         (clk),
    .reset       (rst_n),
    .pixel_en    (pixel_en),
    .hsync       (hs_s),
    .vsync       (vs_s),
    .video_on    (von_s),
    .pixel_x     (px_s),
    .pixel_y     (py_s),
    .line_start  (ls_s),
`ifdef VGA_SYNC_FRAME_CNT_EN
    .frame_start (fs_s),
    .frame_count (fc_s)
`else
    .frame_start (fs_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive pixel_en for one clock, then sample 1 ns after the rising edge.
  task automatic tick(input logic en);
    @(negedge clk);
    pixel_en = en;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    pixel_en = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    pixel_en = 1'b0;
    rst_n    = 1'b0;
    #2;
    total++;
    if ({px, py} !== {10'd799, 10'd524}) begin
      bad++;
      $display("FAIL reset_xy: got (%0d,%0d) want (799,524)", px, py);
    end
    total++;
    if ({hs, vs, von, ls, fs} !== 5'b11000) begin
      bad++;
      $display("FAIL reset_flags: got hs/vs/von/ls/fs=%b want 11000", {hs, vs, von, ls, fs});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    // 1-in-4 strobe pattern: three idle clocks keep the reset position.
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      total++;
      if ({px, py, hs, vs, von} !== {10'd799, 10'd524, 3'b110}) begin
        bad++;
        $display("FAIL post_release_hold: got (%0d,%0d) hs=%b vs=%b von=%b want (799,524) 1 1 0",
                 px, py, hs, vs, von);
      end
    end
    tick(1'b1);
    total++;
    if ({px, py, von, ls, fs} !== {10'd0, 10'd0, 3'b111}) begin
      bad++;
      $display("FAIL first_strobe: got (%0d,%0d) von=%b ls=%b fs=%b want (0,0) 1 1 1",
               px, py, von, ls, fs);
    end
    tick(1'b0);
    total++;
    if ({px, ls, fs} !== {10'd0, 2'b00}) begin
      bad++;
      $display("FAIL pulse_width: got x=%0d ls=%b fs=%b want 0 0 0", px, ls, fs);
    end
    tick(1'b0);
    tick(1'b0);
  endtask

  // Starts at (0,0); runs one full line with 1-in-4 strobes.
  task automatic test_line();
    int hs_low = 0;
    int errs   = 0;
    logic       exp_hs;
    logic       exp_von;
    for (int i = 1; i <= 799; i++) begin
      tick(1'b1);
      exp_hs  = !(i >= 656 && i <= 751);
      exp_von = (i < 640);
      if (hs == 1'b0) hs_low++;
      if ({px, py, hs, von, ls, fs} !== {10'(i), 10'd0, exp_hs, exp_von, 2'b00}) begin
        if (errs < 4)
          $display("FAIL line_pixel: x=%0d y=%0d hs=%b von=%b ls=%b fs=%b want x=%0d y=0 hs=%b von=%b ls=0 fs=0",
                   px, py, hs, von, ls, fs, i, exp_hs, exp_von);
        errs++;
      end
      repeat (3) tick(1'b0);
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (hs_low != 96) begin
      bad++;
      $display("FAIL hsync_width: got %0d strobes low want 96", hs_low);
    end
    tick(1'b1);
    total++;
    if ({px, py, hs, von, ls, fs} !== {10'd0, 10'd1, 4'b1110}) begin
      bad++;
      $display("FAIL line_wrap: got (%0d,%0d) hs=%b von=%b ls=%b fs=%b want (0,1) 1 1 1 0",
               px, py, hs, von, ls, fs);
    end
  endtask

  // Starts at (0,1); stops at x=300, stalls 50 clocks, then resumes.
  task automatic test_stall();
    int errs = 0;
    for (int i = 0; i < 300; i++) tick(1'b1);
    total++;
    if ({px, py} !== {10'd300, 10'd1}) begin
      bad++;
      $display("FAIL stall_entry: got (%0d,%0d) want (300,1)", px, py);
    end
    for (int i = 0; i < 50; i++) begin
      tick(1'b0);
      if ({px, py, hs, vs, von, ls, fs} !== {10'd300, 10'd1, 5'b11100}) begin
        if (errs < 4)
          $display("FAIL stall_hold: got (%0d,%0d) hs=%b vs=%b von=%b ls=%b fs=%b want (300,1) 1 1 1 0 0",
                   px, py, hs, vs, von, ls, fs);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
    tick(1'b1);
    total++;
    if ({px, py, ls} !== {10'd301, 10'd1, 1'b0}) begin
      bad++;
      $display("FAIL stall_resume: got (%0d,%0d) ls=%b want (301,1) 0", px, py, ls);
    end
  endtask

  // Reduced raster, back-to-back strobes: 193 strobes cover two frame starts.
  task automatic test_frame();
    int ex = 15, ey = 11;
    int fs_cnt = 0, ls_cnt = 0, vs_low = 0, errs = 0;
    logic exp_hs, exp_vs, exp_von;
    apply_reset();
    for (int i = 0; i < 193; i++) begin
      tick(1'b1);
      if (ex == 15) begin
        ex = 0;
        ey = (ey == 11) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      exp_hs  = !(ex >= 10 && ex <= 12);
      exp_vs  = !(ey >= 8 && ey <= 9);
      exp_von = (ex < 8) && (ey < 6);
      if (fs_s) fs_cnt++;
      if (ls_s) ls_cnt++;
      if (!vs_s) vs_low++;
      if ({px_s, py_s, hs_s, vs_s, von_s, ls_s, fs_s} !==
          {10'(ex), 10'(ey), exp_hs, exp_vs, exp_von, (ex == 0), (ex == 0 && ey == 0)}) begin
        if (errs < 4)
          $display("FAIL frame_pixel: got (%0d,%0d) hs=%b vs=%b von=%b ls=%b fs=%b want (%0d,%0d) %b %b %b",
                   px_s, py_s, hs_s, vs_s, von_s, ls_s, fs_s, ex, ey, exp_hs, exp_vs, exp_von);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (fs_cnt != 2) begin
      bad++;
      $display("FAIL frame_start_count: got %0d want 2", fs_cnt);
    end
    total++;
    if (ls_cnt != 13) begin
      bad++;
      $display("FAIL line_start_count: got %0d want 13", ls_cnt);
    end
    total++;
    if (vs_low != 32) begin
      bad++;
      $display("FAIL vsync_width: got %0d strobes low want 32", vs_low);
    end
  endtask

  // Reduced raster at (12,9): inside vsync and hsync; reset mid-cycle.
  task automatic test_back_to_back();
    apply_reset();
    for (int i = 0; i < 157; i++) tick(1'b1);
    total++;
    if ({px_s, py_s, hs_s, vs_s} !== {10'd12, 10'd9, 2'b00}) begin
      bad++;
      $display("FAIL b2b_position: got (%0d,%0d) hs=%b vs=%b want (12,9) 0 0",
               px_s, py_s, hs_s, vs_s);
    end
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({px_s, py_s, hs_s, vs_s, von_s, ls_s, fs_s} !== {10'd15, 10'd11, 5'b11000}) begin
      bad++;
      $display("FAIL async_reset_small: got (%0d,%0d) hs=%b vs=%b von=%b ls=%b fs=%b want (15,11) 1 1 0 0 0",
               px_s, py_s, hs_s, vs_s, von_s, ls_s, fs_s);
    end
    total++;
    if ({px, py, hs, vs} !== {10'd799, 10'd524, 2'b11}) begin
      bad++;
      $display("FAIL async_reset_full: got (%0d,%0d) hs=%b vs=%b want (799,524) 1 1", px, py, hs, vs);
    end
    @(negedge clk);
    pixel_en = 1'b0;
    rst_n    = 1'b1;
    tick(1'b1);
    total++;
    if ({px_s, py_s, ls_s, fs_s, px, py, fs} !== {10'd0, 10'd0, 2'b11, 10'd0, 10'd0, 1'b1}) begin
      bad++;
      $display("FAIL b2b_restart: small (%0d,%0d) ls=%b fs=%b full (%0d,%0d) fs=%b want (0,0) 1 1 (0,0) 1",
               px_s, py_s, ls_s, fs_s, px, py, fs);
    end
  endtask

`ifdef VGA_SYNC_FRAME_CNT_EN
  task automatic test_frame_count();
    apply_reset();
    #1;
    total++;
    if (fc_s !== 16'd0) begin
      bad++;
      $display("FAIL fcount_reset: got %0d want 0", fc_s);
    end
    tick(1'b1);
    total++;
    if (fc_s !== 16'd1 || fc !== 16'd1) begin
      bad++;
      $display("FAIL fcount_first: got small=%0d full=%0d want 1", fc_s, fc);
    end
    for (int i = 0; i < 383; i++) tick(1'b1);
    total++;
    if (fc_s !== 16'd2) begin
      bad++;
      $display("FAIL fcount_before_third: got %0d want 2", fc_s);
    end
    tick(1'b1);
    total++;
    if (fc_s !== 16'd3 || fs_s !== 1'b1) begin
      bad++;
      $display("FAIL fcount_third: got %0d fs=%b want 3 1", fc_s, fs_s);
    end
  endtask
`endif

  initial begin
    rst_n    = 1'b1;
    pixel_en = 1'b0;
    test_reset();
    test_line();
    test_stall();
    test_frame();
    test_back_to_back();
`ifdef VGA_SYNC_FRAME_CNT_EN
    test_frame_count();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
